kt_rom_arbiter: RTL and testbench



---
 rtl/kt_rom_arbiter.sv | 165 ++++++++++++++++
 tb/tb_kt_rom_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kt_rom_arbiter.sv
// kt_rom_arbiter: shares the SHA-256 Kt ROM between N_REQ cores, one start-round..63 burst at a time.
// Build option KT_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority (core 0 first).
module kt_rom_arbiter #(
    parameter int         N_REQ      = 2,
    parameter int         N_REQ_LOG2 = 1,
    parameter logic [1:0] ROM_BASE   = 2'b10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [6*N_REQ-1:0]    req_round,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic [7:0]            rom_raddr,
    output logic                  rom_re,
    input  logic [31:0]           rom_rdata,
    output logic                  kt_valid,
    output logic [31:0]           kt_data,
    output logic [5:0]            kt_round,
    output logic                  kt_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'd63;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [N_REQ_LOG2-1:0] owner_q, owner_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic [5:0]            tag_q, tag_d;

    logic                  any_req;
    logic                  owner_req;
    logic                  issue;
    logic [N_REQ_LOG2-1:0] win_idx;
    logic [5:0]            win_round;
    logic [5:0]            round_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_round
            assign round_arr[gi] = req_round[6*gi +: 6];
        end
    endgenerate

    assign any_req   = |req;
    assign owner_req = req[owner_q];
    assign win_round = round_arr[win_idx];

`ifdef KT_ARB_ROUND_ROBIN_EN
    localparam logic [N_REQ_LOG2:0] N_REQ_W = (N_REQ_LOG2+1)'(N_REQ);

    logic [N_REQ_LOG2-1:0] rr_q, rr_d;
    logic [2*N_REQ-1:0]    req_dbl;
    logic [N_REQ-1:0]      req_rot;
    logic [N_REQ_LOG2-1:0] win_off;
    logic [N_REQ_LOG2:0]   win_sum;
    logic [N_REQ_LOG2:0]   rr_sum;

    // Rotate requests so bit 0 is the core at the rr pointer, pick the lowest, rotate back.
    always_comb begin
        req_dbl = {req, req} >> rr_q;
        req_rot = req_dbl[N_REQ-1:0];
        win_off = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (req_rot[k]) win_off = N_REQ_LOG2'(k);
        end
        win_sum = {1'b0, rr_q} + {1'b0, win_off};
        if (win_sum >= N_REQ_W) win_sum = win_sum - N_REQ_W;
        win_idx = win_sum[N_REQ_LOG2-1:0];
    end

    always_comb begin
        rr_sum = {1'b0, owner_q} + (N_REQ_LOG2+1)'(1);
        if (rr_sum >= N_REQ_W) rr_sum = rr_sum - N_REQ_W;
        rr_d = (state_q == DRAIN) ? rr_sum[N_REQ_LOG2-1:0] : rr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (req[k]) win_idx = N_REQ_LOG2'(k);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (!owner_req || cnt_q == LAST_ROUND) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping; the counter saturates at round 63 and never wraps.
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        grant_d = grant_q;
        valid_d = issue;
        tag_d   = issue ? cnt_q : tag_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win_idx;
                    cnt_d   = win_round;
                    grant_d = N_REQ'(1) << win_idx;
                end
            end
            ISSUE: begin
                if (issue && cnt_q != LAST_ROUND) cnt_d = cnt_q + 6'd1;
            end
            DRAIN: begin
                grant_d = '0;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // A delivered word is the last one whenever no further address goes out this cycle.
    always_comb begin
        issue     = (state_q == ISSUE) && owner_req;
        rom_re    = issue;
        rom_raddr = issue ? {ROM_BASE, cnt_q} : 8'h00;
        busy      = (state_q != IDLE);
        grant     = grant_q;
        kt_valid  = valid_q;
        kt_data   = valid_q ? rom_rdata : 32'h0;
        kt_round  = valid_q ? tag_q : 6'd0;
        kt_last   = valid_q && !issue;
    end

endmodule

// File: tb/tb_kt_rom_arbiter.sv
// tb_kt_rom_arbiter: randomized two-core burst traffic checked against a burst-schedule model.
// Build with +define+KT_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_kt_rom_arbiter;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [6*N-1:0] req_round = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [7:0]     rom_raddr;
    logic           rom_re;
    logic [31:0]    rom_rdata = '0;
    logic           kt_valid;
    logic [31:0]    kt_data;
    logic [5:0]     kt_round;
    logic           kt_last;

    kt_rom_arbiter #(.N_REQ(N), .N_REQ_LOG2(1), .ROM_BASE(2'b10)) dut (
        .clk(clk), .reset(reset), .req(req), .req_round(req_round),
        .grant(grant), .busy(busy), .rom_raddr(rom_raddr), .rom_re(rom_re),
        .rom_rdata(rom_rdata), .kt_valid(kt_valid), .kt_data(kt_data),
        .kt_round(kt_round), .kt_last(kt_last)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) if (rom_re) rom_rdata <= mem[rom_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { int cyc; logic [7:0] addr; } iss_t;
    typedef struct { int cyc; logic [5:0] rnd; logic [31:0] data; logic last; logic [N-1:0] gnt; } word_t;
    typedef struct { int cyc; logic busy; logic [N-1:0] gnt; } st_t;

    iss_t  iss_log[$];
    word_t word_log[$];
    st_t   st_log[$];
    iss_t  e_iss[$];
    word_t e_word[$];
    int    b_lo[$], b_hi[$], b_gnt[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (rom_re)   iss_log.push_back('{cyc, rom_raddr});
            if (kt_valid) word_log.push_back('{cyc, kt_round, kt_data, kt_last, grant});
            st_log.push_back('{cyc, busy, grant});
            chk("grant_onehot", 64'($onehot0(grant)), 64'd1);
            if (kt_valid) chk("valid_with_grant", 64'(grant != '0), 64'd1);
        end
    end

    // Scenario description: per-core arrival offset, start round, burst count, abort length (0 = full).
    int sc_a[N], sc_s[N], sc_nb[N], sc_ab[N];
    int rr_m = 0;

    task automatic clear_logs();
        iss_log.delete(); word_log.delete(); st_log.delete();
        e_iss.delete(); e_word.delete(); b_lo.delete(); b_hi.delete(); b_gnt.delete();
    endtask

    task automatic compare_logs();
        int n;
        chk("issue_count", 64'(iss_log.size()), 64'(e_iss.size()));
        n = (iss_log.size() < e_iss.size()) ? iss_log.size() : e_iss.size();
        for (int i = 0; i < n; i++) begin
            chk("issue_cycle", 64'(iss_log[i].cyc), 64'(e_iss[i].cyc));
            chk("rom_raddr", 64'(iss_log[i].addr), 64'(e_iss[i].addr));
        end
        chk("word_count", 64'(word_log.size()), 64'(e_word.size()));
        n = (word_log.size() < e_word.size()) ? word_log.size() : e_word.size();
        for (int i = 0; i < n; i++) begin
            chk("word_cycle", 64'(word_log[i].cyc), 64'(e_word[i].cyc));
            chk("kt_round", 64'(word_log[i].rnd), 64'(e_word[i].rnd));
            chk("kt_data", 64'(word_log[i].data), 64'(e_word[i].data));
            chk("kt_last", 64'(word_log[i].last), 64'(e_word[i].last));
            chk("word_grant", 64'(word_log[i].gnt), 64'(e_word[i].gnt));
        end
        foreach (st_log[i]) begin
            logic          eb;
            logic [N-1:0]  eg;
            eb = 1'b0; eg = '0;
            for (int b = 0; b < b_lo.size(); b++) begin
                if (st_log[i].cyc >= b_lo[b] && st_log[i].cyc <= b_hi[b]) begin
                    eb = 1'b1; eg = N'(b_gnt[b]);
                end
            end
            chk("busy", 64'(st_log[i].busy), 64'(eb));
            chk("grant", 64'(st_log[i].gnt), 64'(eg));
        end
    endtask

    task automatic run_scenario(input string name);
        int base, free_c, d, w, T, L, s, end_c, c;
        bit ab;
        int rem[N], A[N], F[N];
        base = cyc;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            A[i] = base + sc_a[i]; rem[i] = sc_nb[i]; F[i] = A[i];
        end
        free_c = base;
        forever begin
            d = -1;
            for (int i = 0; i < N; i++) if (rem[i] > 0 && (d < 0 || A[i] < d)) d = A[i];
            if (d < 0) break;
            if (free_c > d) d = free_c;
            w = -1;
            for (int k = 0; k < N; k++) begin
`ifdef KT_ARB_ROUND_ROBIN_EN
                c = (rr_m + k) % N;
`else
                c = k;
`endif
                if (w < 0 && rem[c] > 0 && A[c] <= d) w = c;
            end
            s  = sc_s[w];
            T  = d + 1;
            ab = (sc_ab[w] != 0);
            L  = ab ? sc_ab[w] : 64 - s;
            for (int k = 0; k < L; k++) begin
                e_iss.push_back('{T + k, 8'(128 + s + k)});
                e_word.push_back('{T + 1 + k, 6'(s + k), mem[8'(128 + s + k)], (k == L - 1), N'(1) << w});
            end
            b_lo.push_back(T);
            b_hi.push_back(ab ? T + L + 1 : T + L);
            b_gnt.push_back(1 << w);
            rem[w]--;
            if (rem[w] == 0) F[w] = T + L;
            free_c = ab ? T + L + 2 : T + L + 1;
            rr_m = (w + 1) % N;
            $display("%s: burst core=%0d start=%0d words=%0d first_issue=%0d%s",
                     name, w, s, L, T - base, ab ? " aborted" : "");
        end
        end_c = free_c + 3;
        for (int i = 0; i < N; i++) req_round[6*i +: 6] = 6'(sc_s[i]);
        while (cyc <= end_c) begin
            for (int i = 0; i < N; i++) req[i] = (cyc >= A[i]) && (cyc < F[i]);
            tick();
        end
        req = '0;
        compare_logs();
    endtask

    task automatic set_core(input int c, input int a, input int s, input int nb, input int abl);
        sc_a[c] = a; sc_s[c] = s; sc_nb[c] = nb; sc_ab[c] = abl;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rom_re"}, 64'(rom_re), 64'd0);
        chk({tag, "_rom_raddr"}, 64'(rom_raddr), 64'd0);
        chk({tag, "_kt_valid"}, 64'(kt_valid), 64'd0);
        chk({tag, "_kt_data"}, 64'(kt_data), 64'd0);
        chk({tag, "_kt_round"}, 64'(kt_round), 64'd0);
        chk({tag, "_kt_last"}, 64'(kt_last), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, T, s, ab;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        set_core(0, 0, 0, 1, 0);  set_core(1, 0, 0, 0, 0);
        run_scenario("full_burst");
        set_core(0, 0, 63, 1, 0); set_core(1, 0, 0, 0, 0);
        run_scenario("round63");
        set_core(0, 0, 60, 2, 0); set_core(1, 0, 60, 2, 0);
        run_scenario("contend60");
        set_core(0, 0, 0, 1, 10); set_core(1, 2, int'($urandom_range(40, 63)), 1, 0);
        run_scenario("abort10");
        set_core(0, 0, 50, 1, 0); set_core(1, 5, 55, 1, 0);
        run_scenario("late_core1");

        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < N; c++) begin
                s  = int'($urandom_range(30, 63));
                sc_nb[c] = int'($urandom_range(0, 2));
                ab = 0;
                if (sc_nb[c] == 1 && s < 63 && $urandom_range(0, 2) == 0)
                    ab = int'($urandom_range(1, 63 - s));
                set_core(c, int'($urandom_range(0, 6)), s, sc_nb[c], ab);
            end
            run_scenario("random");
        end

        // Reset while round 20 of a full burst is on the output.
        clear_logs();
        base = cyc;
        T = base + 1;
        req_round = '0;
        req = 2'b01;
        while (cyc < base + 22) tick();
        #1;
        chk("pre_reset_valid", 64'(kt_valid), 64'd1);
        chk("pre_reset_round", 64'(kt_round), 64'd20);
        reset = 1'b1;
        req = '0;
        #1;
        check_all_zero("midreset");
        for (int k = 0; k <= 20; k++) e_iss.push_back('{T + k, 8'(128 + k)});
        for (int k = 0; k < 20; k++) e_word.push_back('{T + 1 + k, 6'(k), mem[8'(128 + k)], 1'b0, 2'b01});
        b_lo.push_back(T); b_hi.push_back(base + 21); b_gnt.push_back(1);
        compare_logs();
        $display("reset_mid_burst: words_before_reset=%0d", word_log.size());
        repeat (2) tick();
        reset = 1'b0;
        rr_m = 0;
        clear_logs();
        repeat (6) tick();
        chk("post_reset_words", 64'(word_log.size()), 64'd0);
        chk("post_reset_issues", 64'(iss_log.size()), 64'd0);
        set_core(0, 0, int'($urandom_range(40, 62)), 1, 0);
        set_core(1, 1, int'($urandom_range(40, 63)), 1, 0);
        run_scenario("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
